free_blk_fifo: RTL

Free-block pool for the NVM flash translation path. Holds the physical addresses of erased (clean) blocks, hands them out to the write allocator one per request, and takes back blocks that garbage collection has reclaimed. Sits directly upstream of the GC controller: it supplies `clean_num` and `ini_full`, raises `gc_start` when the pool runs low, and accepts recovered blocks on `fifo_recover_en`.

---
 rtl/NVM_pkg.sv | 15 +
 rtl/blk_fifo_ram.sv | 24 ++
 rtl/free_blk_fifo.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/NVM_pkg.sv
// Shared types and defaults for the NVM flash translation free-block path.
package NVM_pkg;

  localparam int unsigned BLK_ADDR_W_DFLT = 8;
  localparam int unsigned GC_THRESH_DFLT  = 3;

  typedef logic [BLK_ADDR_W_DFLT-1:0] blk_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } free_fifo_state_t;

endpackage

// File: rtl/blk_fifo_ram.sv
// Block-address storage: one synchronous write port, one asynchronous read port.
module blk_fifo_ram #(
  parameter int unsigned AddrW = 4,
  parameter int unsigned DataW = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [2**AddrW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/free_blk_fifo.sv
// Free-block pool: fills itself with consecutive clean block addresses, hands them out
// show-ahead on request and takes back GC-reclaimed blocks.
module free_blk_fifo
  import NVM_pkg::*;
#(
  parameter int unsigned FIFO_SIZE_BIT_NUM = 4,
  parameter int unsigned BLK_ADDR_W        = 8,
  parameter int unsigned INIT_BASE         = 0,
  parameter int unsigned GC_THRESH         = GC_THRESH_DFLT
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         initial_fifo,
  input  logic                         pop_req,
  output logic                         pop_valid,
  output logic [BLK_ADDR_W-1:0]        pop_blk,
  input  logic                         fifo_recover_en,
  input  logic [BLK_ADDR_W-1:0]        recover_blk,
  output logic [FIFO_SIZE_BIT_NUM-1:0] clean_num,
  output logic                         ini_full,
  output logic                         gc_start,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow_err
);

  localparam int unsigned N = FIFO_SIZE_BIT_NUM;
  localparam logic [N-1:0] Cap = {N{1'b1}};
  localparam logic [N-1:0] One = {{(N-1){1'b0}}, 1'b1};
  localparam logic [BLK_ADDR_W-1:0] InitBase = BLK_ADDR_W'(INIT_BASE);

  free_fifo_state_t state_q, state_d;
  logic [N-1:0] wr_ptr_q, wr_ptr_d;
  logic [N-1:0] rd_ptr_q, rd_ptr_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;
  logic         ini_full_q, ini_full_d;
  logic         gc_start_q, gc_start_d;

  logic                  run;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  we;
  logic [BLK_ADDR_W-1:0] wdata;
  logic [BLK_ADDR_W-1:0] rdata;

  assign run     = (state_q == RUN);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == Cap);
  assign pop_ok  = run && !initial_fifo && pop_req && !empty;
  // A pop in the same cycle frees a slot, so a push into a full pool is still accepted.
  assign push_ok = run && !initial_fifo && fifo_recover_en && (!full || pop_ok);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    we       = 1'b0;
    wdata    = recover_blk;

    if (initial_fifo) begin
      state_d  = INIT;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        INIT: begin
          // The write pointer doubles as the init index i.
          we       = 1'b1;
          wdata    = InitBase + BLK_ADDR_W'(wr_ptr_q);
          wr_ptr_d = wr_ptr_q + One;
          cnt_d    = cnt_q + One;
          if (cnt_q == Cap - One) begin
            state_d = RUN;
          end
          if (fifo_recover_en) begin
            ovf_d = 1'b1;
          end
        end
        RUN: begin
          if (push_ok) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + One;
          end
          if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + One;
          end
          if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + One;
          end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - One;
          end
          if (fifo_recover_en && !push_ok) begin
            ovf_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    ini_full_d = (state_d == RUN);
    gc_start_d = (state_d == RUN) && (32'(cnt_d) <= GC_THRESH);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      ini_full_q <= 1'b0;
      gc_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      ini_full_q <= ini_full_d;
      gc_start_q <= gc_start_d;
    end
  end

  blk_fifo_ram #(
    .AddrW (N),
    .DataW (BLK_ADDR_W)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign pop_valid    = pop_ok;
  assign pop_blk      = (run && !empty) ? rdata : '0;
  assign clean_num    = cnt_q;
  assign ini_full     = ini_full_q;
  assign gc_start     = gc_start_q;
  assign overflow_err = ovf_q;

endmodule
